// File: rtl/status_fifo_pkg.sv
// status_fifo_pkg
//   Shared definitions for the status FIFO: the width of one status word,
//   the field slices inside it, and a helper that packs the three status
//   vectors into one word in the default order
//   {pcs_pma_status_vector, mac_status_vector, pcspma_status}.
package status_fifo_pkg;

    localparam int unsigned STATUS_W = 458;

    // Field slices within one status word
    localparam int unsigned PCSPMA_LSB     = 0;
    localparam int unsigned PCSPMA_MSB     = 7;
    localparam int unsigned MAC_SV_LSB     = 8;
    localparam int unsigned MAC_SV_MSB     = 9;
    localparam int unsigned PCS_PMA_SV_LSB = 10;
    localparam int unsigned PCS_PMA_SV_MSB = 457;

    localparam int unsigned PCSPMA_W     = PCSPMA_MSB - PCSPMA_LSB + 1;
    localparam int unsigned MAC_SV_W     = MAC_SV_MSB - MAC_SV_LSB + 1;
    localparam int unsigned PCS_PMA_SV_W = PCS_PMA_SV_MSB - PCS_PMA_SV_LSB + 1;

    // First member lands in the most significant bits
    typedef struct packed {
        logic [PCS_PMA_SV_W-1:0] pcs_pma_status_vector;
        logic [MAC_SV_W-1:0]     mac_status_vector;
        logic [PCSPMA_W-1:0]     pcspma_status;
    } status_t;

    function automatic status_t pack_status(
        input logic [PCSPMA_W-1:0]     pcspma_status,
        input logic [MAC_SV_W-1:0]     mac_status_vector,
        input logic [PCS_PMA_SV_W-1:0] pcs_pma_status_vector
    );
        status_t s;
        s.pcs_pma_status_vector = pcs_pma_status_vector;
        s.mac_status_vector     = mac_status_vector;
        s.pcspma_status         = pcspma_status;
        return s;
    endfunction

endpackage

// File: rtl/status_fifo_if.sv
// status_fifo_if
//   Write/read handshake and status bundle of the status FIFO.
//   master : producer/consumer side - drives din, wr_en, rd_en.
//   slave  : FIFO side - drives dout, full, empty, data_count,
//            overflow, underflow.
interface status_fifo_if
    import status_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STATUS_W,
    parameter int unsigned DEPTH      = 16
);

    logic [DATA_WIDTH-1:0]      din;
    logic                       wr_en;
    logic                       rd_en;
    logic [DATA_WIDTH-1:0]      dout;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     data_count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, data_count, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, data_count, overflow, underflow
    );

endinterface

// File: rtl/status_fifo_ram.sv
// status_fifo_ram
//   DEPTH x DATA_WIDTH storage for the status FIFO. Contents are not reset.
//   core_clk : write clock
//   we       : write enable
//   waddr    : write address
//   wdata    : write data
//   raddr    : asynchronous read address
//   rdata    : asynchronous read data
module status_fifo_ram
    import status_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STATUS_W,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       core_clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge core_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/status_fifo.sv
// status_fifo
//   First-word-fall-through FIFO for status words.
//   core_clk    : sole clock, rising edge
//   core_resetn : asynchronous active-low reset
//   fifo_bus    : slave side of status_fifo_if
//                 din/wr_en      - push at the tail (dropped while full)
//                 rd_en          - pop the head (ignored while empty)
//                 dout           - head entry, held while empty
//                 full/empty/data_count - registered occupancy
//                 overflow/underflow    - one-cycle pulses for a write
//                                         while full / read while empty
module status_fifo
    import status_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STATUS_W,
    parameter int unsigned DEPTH      = 16
) (
    input  logic          core_clk,
    input  logic          core_resetn,
    status_fifo_if.slave  fifo_bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW-1:0]         head_next_addr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = fifo_bus.wr_en & ~full_q;
    assign rd_acc = fifo_bus.rd_en & ~empty_q;

    // The RAM read port always looks one entry past the head, so that on a
    // pop the next head is ready to be loaded into the dout register.
    assign head_next_addr = rd_ptr_q + AW'(1);

    status_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .core_clk (core_clk),
        .we       (wr_acc),
        .waddr    (wr_ptr_q),
        .wdata    (fifo_bus.din),
        .raddr    (head_next_addr),
        .rdata    (ram_rdata)
    );

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_resetn) begin
        if (!core_resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
            overflow_q  <= fifo_bus.wr_en & full_q;
            underflow_q <= fifo_bus.rd_en & empty_q;
        end
    end

    // dout is a register holding the current head. It is loaded from din
    // when the incoming word becomes the head (FIFO empty, or the last entry
    // is popped in the same cycle), from the look-ahead RAM port on a pop
    // with more entries behind, and otherwise held - which also keeps the
    // last popped word visible while empty.
    always_ff @(posedge core_clk or negedge core_resetn) begin
        if (!core_resetn) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            if (count_q != CW'(1)) begin
                dout_q <= ram_rdata;
            end else if (wr_acc) begin
                dout_q <= fifo_bus.din;
            end
        end else if (wr_acc && empty_q) begin
            dout_q <= fifo_bus.din;
        end
    end

    assign fifo_bus.dout       = dout_q;
    assign fifo_bus.full       = full_q;
    assign fifo_bus.empty      = empty_q;
    assign fifo_bus.data_count = count_q;
    assign fifo_bus.overflow   = overflow_q;
    assign fifo_bus.underflow  = underflow_q;

endmodule

// File: tb/tb_status_fifo.sv
// tb_status_fifo
//   Self-checking bench for status_fifo. A reference process keeps the
//   expected contents as a queue of words and an occupancy count; a monitor
//   on the falling edge compares flags, count, pulses and dout against it
//   and pops the expected head whenever a read is being presented.
module tb_status_fifo;
    import status_fifo_pkg::*;

    localparam int unsigned DW = STATUS_W;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = $clog2(D) + 1;

    logic core_clk;
    logic core_resetn;

    status_fifo_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

    status_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (D)
    ) dut (
        .core_clk    (core_clk),
        .core_resetn (core_resetn),
        .fifo_bus    (bus)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_q[$];
    int            mdl_cnt;
    logic          mdl_ovf;
    logic          mdl_udf;
    logic [DW-1:0] last_head;

    always @(posedge core_clk or negedge core_resetn) begin
        if (!core_resetn) begin
            exp_q.delete();
            mdl_cnt <= 0;
            mdl_ovf <= 1'b0;
            mdl_udf <= 1'b0;
        end else begin
            mdl_ovf <= bus.wr_en && (mdl_cnt == int'(D));
            mdl_udf <= bus.rd_en && (mdl_cnt == 0);
            if (bus.wr_en && mdl_cnt < int'(D)) begin
                exp_q.push_back(bus.din);
            end
            mdl_cnt <= mdl_cnt + ((bus.wr_en && mdl_cnt < int'(D)) ? 1 : 0)
                               - ((bus.rd_en && mdl_cnt > 0) ? 1 : 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge core_clk) begin
        if (!core_resetn) begin
            last_head = '0;
        end else begin
            chk("empty", DW'(bus.empty), DW'(mdl_cnt == 0));
            chk("full", DW'(bus.full), DW'(mdl_cnt == int'(D)));
            chk("data_count", DW'(bus.data_count), DW'(mdl_cnt));
            chk("overflow", DW'(bus.overflow), DW'(mdl_ovf));
            chk("underflow", DW'(bus.underflow), DW'(mdl_udf));
            if (mdl_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", DW'(0), DW'(1));
                end else begin
                    chk(bus.rd_en ? "rd_data" : "head_data", bus.dout, exp_q[0]);
                    last_head = exp_q[0];
                    if (bus.rd_en) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("dout_hold", bus.dout, last_head);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] rand_word();
        logic [PCS_PMA_SV_W-1:0] v;
        for (int i = 0; i < PCS_PMA_SV_W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return pack_status(PCSPMA_W'($urandom), MAC_SV_W'($urandom), v);
    endfunction

    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
        @(posedge core_clk);
        #1;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
    endtask

    int reads;

    initial begin
        core_resetn = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.din     = '0;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        core_resetn = 1'b1;

        // reset then idle
        @(posedge core_clk);
        #1;
        chk("rst_empty", DW'(bus.empty), DW'(1));
        chk("rst_full", DW'(bus.full), DW'(0));
        chk("rst_count", DW'(bus.data_count), DW'(0));
        chk("rst_dout", bus.dout, '0);

        // single word in and out
        drive(1'b1, 1'b0, DW'(12'h0A5));
        drive(1'b0, 1'b0, '0);
        chk("one_dout", bus.dout, DW'(12'h0A5));
        chk("one_count", DW'(bus.data_count), DW'(1));
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        chk("one_empty", DW'(bus.empty), DW'(1));

        // fill, overflow, drain
        for (int i = 1; i <= int'(D); i++) begin
            drive(1'b1, 1'b0, DW'(i));
        end
        drive(1'b1, 1'b0, DW'(8'hFF));
        chk("fill_full", DW'(bus.full), DW'(1));
        chk("fill_count", DW'(bus.data_count), DW'(D));
        drive(1'b0, 1'b0, '0);
        chk("ovf_pulse", DW'(bus.overflow), DW'(1));
        for (int i = 1; i <= int'(D); i++) begin
            drive(1'b0, 1'b1, '0);
        end
        drive(1'b0, 1'b0, '0);
        chk("drained", DW'(bus.empty), DW'(1));

        // simultaneous read/write at full and at empty
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b1, 1'b0, rand_word());
        end
        drive(1'b1, 1'b1, rand_word());
        drive(1'b0, 1'b0, '0);
        chk("full_rw_count", DW'(bus.data_count), DW'(D - 1));
        chk("full_rw_ovf", DW'(bus.overflow), DW'(1));
        for (int i = 0; i < int'(D) - 1; i++) begin
            drive(1'b0, 1'b1, '0);
        end
        drive(1'b1, 1'b1, DW'(16'hBEEF));
        drive(1'b0, 1'b0, '0);
        chk("empty_rw_count", DW'(bus.data_count), DW'(1));
        chk("empty_rw_udf", DW'(bus.underflow), DW'(1));
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);

        // continuous streaming, wr_en=!full, rd_en=!empty
        reads = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge core_clk);
            #1;
            bus.wr_en = !bus.full;
            bus.rd_en = !bus.empty;
            bus.din   = DW'(1000 + i);
            if (bus.rd_en) reads++;
        end
        chk("stream_reads", DW'(reads), DW'(99));
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);

        // randomized traffic, fill-biased then drain-biased
        for (int i = 0; i < 1500; i++) begin
            int unsigned wp;
            wp = (i < 750) ? 70 : 30;
            drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp,
                  rand_word());
        end
        drive(1'b0, 1'b0, '0);

        // asynchronous reset with entries held
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, rand_word());
        end
        drive(1'b0, 1'b0, '0);
        @(posedge core_clk);
        #2;
        core_resetn = 1'b0;
        #1;
        chk("async_rst_empty", DW'(bus.empty), DW'(1));
        chk("async_rst_count", DW'(bus.data_count), DW'(0));
        chk("async_rst_dout", bus.dout, '0);
        @(negedge core_clk);
        @(negedge core_clk);
        core_resetn = 1'b1;
        bus.wr_en   = 1'b1;
        bus.din     = DW'(32'hC0FFEE);
        drive(1'b0, 1'b1, '0);
        chk("post_rst_first", bus.dout, DW'(32'hC0FFEE));
        drive(1'b0, 1'b0, '0);
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        #1;
        chk("final_scoreboard", DW'(exp_q.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
